cpu_dma_bus_master: RTL and testbench
=====================================

Name: cpu_dma_bus_master

Overview:
- Next-state and output stage of the CPU_SM DMA bus master. Its registered state feeds the cpudffN product-term flops.
- Arbitrates for the 68030 bus (BR_/BG_/BGACK_) and runs long-word DMA cycles between the SCSI FIFO and memory.
- Issues one-cycle FIFO and address-counter strobes.
- Sits between the DMA control registers / FIFO flags and the CPU bus pads.

Parameters:
- BURST_LEN, 4, long-word transfers per bus tenure (1..15).
- WDOG_CYCLES, 255, BCLK cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- BCLK  in  1  bus clock; all state changes on rising edge.
- CCRESET  in  1  reset; synchronous, active-high.
- DMAENA  in  1  DMA enabled by control register.
- DMADIR  in  1  0 = memory->FIFO (read), 1 = FIFO->memory (write).
- FIFOFULL  in  1  FIFO cannot accept a long word.
- FIFOEMPTY  in  1  FIFO has no long word.
- BG_  in  1  bus grant, active-low.
- AS_I_  in  1  bus address strobe as seen on pads, active-low.
- BGACK_I_  in  1  bus grant-ack from other masters, active-low.
- STERM_  in  1  synchronous termination, active-low.
- DSACK0_  in  1  async termination, active-low.
- DSACK1_  in  1  async termination, active-low.
- BERR_  in  1  bus error, active-low.
- BR_  out  1  bus request.
- BGACK_  out  1  bus grant acknowledge.
- AS_  out  1  address strobe.
- DS_  out  1  data strobe.
- R_W  out  1  1 = read, 0 = write.
- INCFIFO  out  1  one-cycle pulse: push long word into FIFO (read).
- DECFIFO  out  1  one-cycle pulse: pop long word from FIFO (write).
- A_INC  out  1  one-cycle pulse: address counter +4.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  sticky bus-error/abort flag.

Behaviour:
- Reset (CCRESET high at edge), from any state including mid-cycle:
  - State returns to IDLE; beat counter cleared; ERR cleared.
  - BR_ = BGACK_ = AS_ = DS_ = R_W = 1; INCFIFO = DECFIFO = A_INC = BUSY = 0.
- "ready" = DMAENA & (DMADIR ? !FIFOEMPTY : !FIFOFULL).
- IDLE:
  - If ready & !ERR: go to REQ.
  - If DMAENA = 0: clear ERR.
- REQ:
  - Drive BR_ = 0.
  - Stay until BG_ = 0 & AS_I_ = 1 & BGACK_I_ = 1 in the same cycle, then go to ACK.
  - If DMAENA drops while in REQ: go to IDLE, BR_ released.
- ACK: BGACK_ = 0, BR_ = 1; go to ADDR after one cycle.
- ADDR:
  - AS_ = 0, R_W = ~DMADIR.
  - For a read, DS_ = 0 in the same cycle.
  - Go to WAIT.
- WAIT:
  - Hold AS_ = 0 and DS_ = 0 (a write asserts DS_ on entry to WAIT).
  - Termination = STERM_ = 0, or DSACK1_ = 0 & DSACK0_ = 0.
  - On termination in cycle n: INCFIFO (read) or DECFIFO (write) plus A_INC pulse in cycle n+1; go to TERM.
  - BERR_ = 0 has priority over STERM_/DSACK in the same cycle: set ERR, no FIFO or address pulse, go to TERM.
- TERM:
  - AS_ = DS_ = 1; beat counter +1 (not incremented on BERR).
  - If ERR, or beat = BURST_LEN, or !ready: go to REL. Otherwise go to ADDR.
- REL: BGACK_ = 1; clear beat counter; go to IDLE.
- Beat counter is 4 bits and saturates at BURST_LEN; it never wraps.
- Minimum latency:
  - DMAENA sampled high -> BR_ low at +1 cycle.
  - Grant sampled -> BGACK_ low at +1 cycle, AS_ low at +2 cycles.
- A BGACK_ tenure always ends with AS_ = 1 at least one cycle before BGACK_ = 1.

Optional Feature:
- CPU_SM_WATCHDOG_EN defined:
  - A counter runs while in WAIT.
  - Reaching WDOG_CYCLES without termination sets ERR and forces TERM -> REL.
  - The counter clears on leaving WAIT and on reset.
- Not defined: no counter; WAIT holds indefinitely; WDOG_CYCLES is ignored.

Decomposition:
- cpu_sm_pkg holds:
  - State encoding: IDLE, REQ, ACK, ADDR, WAIT, TERM, REL. One-hot, so cpudffN terms can tap bits.
  - Direction constants DIR_RD = 0, DIR_WR = 1.
  - Beat counter width constant.
- Sub-module cpu_sm_watchdog: counter with clear/enable/terminal-count output. Instantiated only under CPU_SM_WATCHDOG_EN.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: CCRESET high while AS_ = 0.
  - Response: next edge gives AS_ = DS_ = BGACK_ = BR_ = 1, BUSY = 0, ERR = 0.
- Read burst:
  - Stimulus: DMADIR = 0, FIFOFULL = 0, grant after 3 cycles, STERM_ low 1 cycle after each ADDR.
  - Response: exactly 4 INCFIFO and 4 A_INC pulses, R_W = 1, then BGACK_ high.
- Write with DSACK:
  - Stimulus: DMADIR = 1, FIFOEMPTY goes high after 2 pops.
  - Response: 2 DECFIFO pulses, R_W = 0, DS_ asserted one cycle after AS_, early REL.
- Bus error:
  - Stimulus: BERR_ and STERM_ low together in the first beat.
  - Response: ERR = 1, no INCFIFO, REL next, stays IDLE until DMAENA = 0.
- Busy bus:
  - Stimulus: BG_ = 0 but AS_I_ = 0 for 5 cycles.
  - Response: remains in REQ with BR_ = 0; ACK on the first cycle AS_I_ = 1.
- Watchdog (CPU_SM_WATCHDOG_EN, WDOG_CYCLES = 8):
  - Stimulus: no termination.
  - Response: ERR set after 8 WAIT cycles, AS_ released, BGACK_ released one cycle later.

Source files
------------

// File: rtl/cpu_sm_pkg.sv
// CPU_SM DMA bus master: shared state encoding, direction codes and helpers.
package cpu_sm_pkg;

    // One-hot so the downstream cpudffN product terms can tap single bits.
    typedef enum logic [6:0] {
        ST_IDLE = 7'b000_0001,
        ST_REQ  = 7'b000_0010,
        ST_ACK  = 7'b000_0100,
        ST_ADDR = 7'b000_1000,
        ST_WAIT = 7'b001_0000,
        ST_TERM = 7'b010_0000,
        ST_REL  = 7'b100_0000
    } cpu_state_e;

    localparam logic DIR_RD = 1'b0;  // memory -> FIFO
    localparam logic DIR_WR = 1'b1;  // FIFO -> memory

    localparam int BEAT_W = 4;

    // Normal cycle termination: synchronous STERM_ or a 32-bit DSACK pair.
    function automatic logic bus_term(input logic sterm_n,
                                      input logic dsack0_n,
                                      input logic dsack1_n);
        return !sterm_n || (!dsack0_n && !dsack1_n);
    endfunction

endpackage

// File: rtl/cpu_sm_watchdog.sv
// WAIT-state watchdog for the CPU_SM bus master. Counts cycles while enabled
// and flags the last allowed cycle; only built with CPU_SM_WATCHDOG_EN.
module cpu_sm_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic BCLK,
    input  logic CCRESET,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Terminal count is the LIMIT-th consecutive enabled cycle.
    assign tc = en && (cnt_q == CNT_W'(LIMIT - 1));

    // Count enabled cycles; hold at terminal count, restart whenever cleared.
    always_ff @(posedge BCLK) begin
        if (CCRESET || clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_dma_bus_master.sv
// CPU_SM DMA bus master: next-state and output stage. Arbitrates for the
// 68030 bus and runs long-word DMA cycles between the SCSI FIFO and memory.
// Optional: define CPU_SM_WATCHDOG_EN to abort WAIT after WDOG_CYCLES clocks.
module cpu_dma_bus_master
    import cpu_sm_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 4,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic BCLK,
    input  logic CCRESET,
    input  logic DMAENA,
    input  logic DMADIR,
    input  logic FIFOFULL,
    input  logic FIFOEMPTY,
    input  logic BG_,
    input  logic AS_I_,
    input  logic BGACK_I_,
    input  logic STERM_,
    input  logic DSACK0_,
    input  logic DSACK1_,
    input  logic BERR_,
    output logic BR_,
    output logic BGACK_,
    output logic AS_,
    output logic DS_,
    output logic R_W,
    output logic INCFIFO,
    output logic DECFIFO,
    output logic A_INC,
    output logic BUSY,
    output logic ERR
);

    cpu_state_e        state_q;
    logic [BEAT_W-1:0] beat_q;
    logic              ready;
    logic              term;
    logic              grant;
    logic              burst_done;
    logic              wdog_tc;

    assign ready      = DMAENA && ((DMADIR == DIR_WR) ? !FIFOEMPTY : !FIFOFULL);
    assign term       = bus_term(STERM_, DSACK0_, DSACK1_);
    assign grant      = !BG_ && AS_I_ && BGACK_I_;
    assign burst_done = (beat_q == BEAT_W'(BURST_LEN));

`ifdef CPU_SM_WATCHDOG_EN
    cpu_sm_watchdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .BCLK    (BCLK),
        .CCRESET (CCRESET),
        .clr     (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .tc      (wdog_tc)
    );
`else
    // Without the watchdog WAIT holds until the bus terminates the cycle.
    logic unused_wdog;
    assign wdog_tc     = 1'b0;
    assign unused_wdog = (WDOG_CYCLES == 0);
`endif

    // State, beat counter and all bus outputs advance together each BCLK.
    always_ff @(posedge BCLK) begin
        if (CCRESET) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            ERR     <= 1'b0;
            BR_     <= 1'b1;
            BGACK_  <= 1'b1;
            AS_     <= 1'b1;
            DS_     <= 1'b1;
            R_W     <= 1'b1;
            INCFIFO <= 1'b0;
            DECFIFO <= 1'b0;
            A_INC   <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            // NOTE: strobes default low here so every set below is a one-cycle pulse;
            // non-blocking assignments keep all flops sampling pre-edge values.
            INCFIFO <= 1'b0;
            DECFIFO <= 1'b0;
            A_INC   <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (!DMAENA) begin
                        ERR <= 1'b0;
                    end
                    if (ready && !ERR) begin
                        state_q <= ST_REQ;
                        BR_     <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (!DMAENA) begin
                        state_q <= ST_IDLE;
                        BR_     <= 1'b1;
                        BUSY    <= 1'b0;
                    end else if (grant) begin
                        state_q <= ST_ACK;
                        BR_     <= 1'b1;
                        BGACK_  <= 1'b0;
                    end
                end

                ST_ACK: begin
                    state_q <= ST_ADDR;
                    AS_     <= 1'b0;
                    R_W     <= (DMADIR == DIR_RD);
                    DS_     <= (DMADIR == DIR_WR);
                end

                ST_ADDR: begin
                    // Writes present data for a cycle before DS_ qualifies it.
                    state_q <= ST_WAIT;
                    DS_     <= 1'b0;
                end

                ST_WAIT: begin
                    if (!BERR_) begin
                        state_q <= ST_TERM;
                        ERR     <= 1'b1;
                        AS_     <= 1'b1;
                        DS_     <= 1'b1;
                        R_W     <= 1'b1;
                    end else if (term) begin
                        state_q <= ST_TERM;
                        AS_     <= 1'b1;
                        DS_     <= 1'b1;
                        R_W     <= 1'b1;
                        INCFIFO <= R_W;
                        DECFIFO <= !R_W;
                        A_INC   <= 1'b1;
                        if (!burst_done) begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end else if (wdog_tc) begin
                        state_q <= ST_TERM;
                        ERR     <= 1'b1;
                        AS_     <= 1'b1;
                        DS_     <= 1'b1;
                        R_W     <= 1'b1;
                    end
                end

                ST_TERM: begin
                    if (ERR || burst_done || !ready) begin
                        state_q <= ST_REL;
                        BGACK_  <= 1'b1;
                        beat_q  <= '0;
                    end else begin
                        state_q <= ST_ADDR;
                        AS_     <= 1'b0;
                        R_W     <= (DMADIR == DIR_RD);
                        DS_     <= (DMADIR == DIR_WR);
                    end
                end

                ST_REL: begin
                    state_q <= ST_IDLE;
                    BUSY    <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    beat_q  <= '0;
                    BR_     <= 1'b1;
                    BGACK_  <= 1'b1;
                    AS_     <= 1'b1;
                    DS_     <= 1'b1;
                    R_W     <= 1'b1;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_dma_bus_master.sv
// Self-checking bench for cpu_dma_bus_master: reset, read burst, write with
// DSACK and early release, bus error, busy bus, reset mid-WAIT and (with
// CPU_SM_WATCHDOG_EN) the WAIT watchdog. Strobes are scoreboarded.
module tb_cpu_dma_bus_master;

    logic BCLK = 1'b0;
    logic CCRESET, DMAENA, DMADIR, FIFOFULL, FIFOEMPTY;
    logic BG_, AS_I_, BGACK_I_, STERM_, DSACK0_, DSACK1_, BERR_;
    logic BR_, BGACK_, AS_, DS_, R_W, INCFIFO, DECFIFO, A_INC, BUSY, ERR;

    int n_checks = 0;
    int n_fail   = 0;
    int inc_cnt  = 0;
    int dec_cnt  = 0;
    int a_cnt    = 0;

    // Expected {INCFIFO, DECFIFO, A_INC} per terminated beat.
    logic [2:0] exp_q[$];

    always #5 BCLK = ~BCLK;

    cpu_dma_bus_master #(
        .BURST_LEN   (4),
        .WDOG_CYCLES (8)
    ) dut (
        .BCLK      (BCLK),
        .CCRESET   (CCRESET),
        .DMAENA    (DMAENA),
        .DMADIR    (DMADIR),
        .FIFOFULL  (FIFOFULL),
        .FIFOEMPTY (FIFOEMPTY),
        .BG_       (BG_),
        .AS_I_     (AS_I_),
        .BGACK_I_  (BGACK_I_),
        .STERM_    (STERM_),
        .DSACK0_   (DSACK0_),
        .DSACK1_   (DSACK1_),
        .BERR_     (BERR_),
        .BR_       (BR_),
        .BGACK_    (BGACK_),
        .AS_       (AS_),
        .DS_       (DS_),
        .R_W       (R_W),
        .INCFIFO   (INCFIFO),
        .DECFIFO   (DECFIFO),
        .A_INC     (A_INC),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge BCLK);
        #1;
    endtask

    // Strobe monitor: every pulse cycle consumes one scoreboard entry.
    always @(negedge BCLK) begin
        if (!CCRESET && (INCFIFO || DECFIFO || A_INC)) begin
            if (INCFIFO) inc_cnt++;
            if (DECFIFO) dec_cnt++;
            if (A_INC)   a_cnt++;
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", {INCFIFO, DECFIFO, A_INC}, 3'b000);
            end else begin
                check("pulse", {INCFIFO, DECFIFO, A_INC}, exp_q.pop_front());
            end
        end
    end

    // Grant the bus (DUT already in REQ); ends in the ADDR cycle.
    task automatic grant_seq();
        BG_ = 1'b0;
        tick();
        check("bgack_lat", BGACK_, 1'b0);
        check("br_released", BR_, 1'b1);
        BG_ = 1'b1;
        tick();
        check("as_lat", AS_, 1'b0);
    endtask

    // One beat: kind 0 = STERM_, 1 = DSACK pair, 2 = BERR_ with STERM_.
    // Ends in the TERM cycle.
    task automatic do_beat(input logic dir, input int kind);
        int n = 0;
        while (AS_ !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("as_addr", AS_, 1'b0);
        check("r_w", R_W, !dir);
        check("ds_addr", DS_, dir);
        tick();
        check("ds_wait", DS_, 1'b0);
        check("as_wait", AS_, 1'b0);
        if (kind == 1) begin
            DSACK0_ = 1'b0;
            DSACK1_ = 1'b0;
        end else begin
            STERM_ = 1'b0;
        end
        if (kind == 2) begin
            BERR_ = 1'b0;
        end else begin
            exp_q.push_back(dir ? 3'b011 : 3'b101);
        end
        tick();
        STERM_  = 1'b1;
        DSACK0_ = 1'b1;
        DSACK1_ = 1'b1;
        BERR_   = 1'b1;
        check("as_term", AS_, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int inc0, dec0, a0;

        CCRESET = 1'b1; DMAENA = 1'b0; DMADIR = 1'b0; FIFOFULL = 1'b0; FIFOEMPTY = 1'b0;
        BG_ = 1'b1; AS_I_ = 1'b1; BGACK_I_ = 1'b1;
        STERM_ = 1'b1; DSACK0_ = 1'b1; DSACK1_ = 1'b1; BERR_ = 1'b1;
        tick();
        tick();
        check("rst_br", BR_, 1'b1);
        check("rst_bgack", BGACK_, 1'b1);
        check("rst_as_ds", {AS_, DS_}, 2'b11);
        check("rst_rw", R_W, 1'b1);
        check("rst_busy_err", {BUSY, ERR}, 2'b00);
        check("rst_pulses", {INCFIFO, DECFIFO, A_INC}, 3'b000);
        CCRESET = 1'b0;
        tick();

        // Read burst, grant after 3 cycles, full BURST_LEN beats.
        inc0 = inc_cnt; dec0 = dec_cnt; a0 = a_cnt;
        DMADIR = 1'b0; DMAENA = 1'b1;
        tick();
        check("br_lat", BR_, 1'b0);
        check("busy_req", BUSY, 1'b1);
        repeat (3) begin
            tick();
            check("br_hold", BR_, 1'b0);
        end
        grant_seq();
        for (int i = 0; i < 4; i++) do_beat(1'b0, 0);
        tick();
        check("rd_bgack_rel", BGACK_, 1'b1);
        DMAENA = 1'b0;
        tick();
        check("rd_idle", BUSY, 1'b0);
        check("rd_inc", inc_cnt - inc0, 4);
        check("rd_ainc", a_cnt - a0, 4);
        check("rd_dec", dec_cnt - dec0, 0);

        // Write with DSACK behind a busy bus; FIFO empties after 2 pops.
        inc0 = inc_cnt; dec0 = dec_cnt; a0 = a_cnt;
        DMADIR = 1'b1; DMAENA = 1'b1;
        tick();
        check("wr_br", BR_, 1'b0);
        BG_ = 1'b0; AS_I_ = 1'b0;
        repeat (5) begin
            tick();
            check("busy_br", BR_, 1'b0);
            check("busy_bgack", BGACK_, 1'b1);
        end
        AS_I_ = 1'b1;
        tick();
        check("busy_ack", BGACK_, 1'b0);
        BG_ = 1'b1;
        tick();
        do_beat(1'b1, 1);
        do_beat(1'b1, 1);
        FIFOEMPTY = 1'b1;
        tick();
        check("wr_early_rel", BGACK_, 1'b1);
        DMAENA = 1'b0;
        tick();
        FIFOEMPTY = 1'b0;
        check("wr_idle", BUSY, 1'b0);
        check("wr_dec", dec_cnt - dec0, 2);
        check("wr_ainc", a_cnt - a0, 2);
        check("wr_inc", inc_cnt - inc0, 0);

        // Bus error on first beat, with STERM_ also low.
        inc0 = inc_cnt;
        DMADIR = 1'b0; DMAENA = 1'b1;
        tick();
        grant_seq();
        do_beat(1'b0, 2);
        check("berr_err", ERR, 1'b1);
        tick();
        check("berr_rel", BGACK_, 1'b1);
        tick();
        check("berr_idle", BUSY, 1'b0);
        repeat (3) begin
            tick();
            check("berr_stay_br", BR_, 1'b1);
            check("berr_stay_busy", BUSY, 1'b0);
        end
        check("berr_sticky", ERR, 1'b1);
        DMAENA = 1'b0;
        tick();
        check("berr_clear", ERR, 1'b0);
        check("berr_no_inc", inc_cnt - inc0, 0);

        // Reset while the bus cycle is outstanding.
        DMAENA = 1'b1;
        tick();
        grant_seq();
        tick();
        check("mid_wait_as", AS_, 1'b0);
        CCRESET = 1'b1;
        DMAENA  = 1'b0;
        tick();
        check("mrst_strobes", {AS_, DS_, BGACK_, BR_}, 4'b1111);
        check("mrst_busy_err", {BUSY, ERR}, 2'b00);
        CCRESET = 1'b0;
        tick();

`ifdef CPU_SM_WATCHDOG_EN
        // No termination: abort after 8 WAIT cycles.
        DMAENA = 1'b1;
        tick();
        grant_seq();
        repeat (8) begin
            tick();
            check("wd_wait_as", AS_, 1'b0);
        end
        tick();
        check("wd_err", ERR, 1'b1);
        check("wd_as_rel", AS_, 1'b1);
        check("wd_bgack_held", BGACK_, 1'b0);
        tick();
        check("wd_bgack_rel", BGACK_, 1'b1);
        DMAENA = 1'b0;
        tick();
        tick();
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
